// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access,
// with a fetch anti-starvation limit and an access timeout.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_D_STREAK = 4,
  parameter int TIMEOUT      = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack
);

  localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
  localparam int TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t              state, state_next;
  logic                owner_d;
  logic [STREAK_W-1:0] streak;
  logic [TMO_W-1:0]    tmo_cnt;
  logic                d_pend, grant_d, grant_i, abort, finish;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_d || grant_i) state_next = BUSY;
      BUSY:    if (finish) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Data wins contention until it has taken MAX_D_STREAK grants in a row.
  always_comb begin
    d_pend  = d_read | d_write;
    grant_d = 1'b0;
    grant_i = 1'b0;
    abort   = 1'b0;
    finish  = 1'b0;
    case (state)
      IDLE: begin
        grant_d = d_pend && (!if_req || (streak < STREAK_W'(MAX_D_STREAK)));
        grant_i = if_req && !grant_d;
      end
      BUSY: begin
        abort  = !mem_ack && (tmo_cnt == TMO_W'(TIMEOUT - 1));
        finish = mem_ack || abort;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
      err       <= 1'b0;
      owner_d   <= 1'b0;
      streak    <= '0;
      tmo_cnt   <= '0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      err      <= 1'b0;
      if (grant_d || grant_i) begin
        mem_req   <= 1'b1;
        owner_d   <= grant_d;
        mem_we    <= grant_d & d_write;
        mem_addr  <= grant_d ? d_addr : if_addr;
        mem_wdata <= grant_d ? d_wdata : '0;
        tmo_cnt   <= '0;
        streak    <= (grant_d && if_req) ? streak + 1'b1 : '0;
      end
      if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (finish) begin
          mem_req <= 1'b0;
          err     <= abort;
          if (owner_d) begin
            d_ready <= 1'b1;
            d_rdata <= abort ? '0 : mem_rdata;
          end else begin
            if_ready <= 1'b1;
            if_rdata <= abort ? '0 : mem_rdata;
          end
        end
      end
    end
  end

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (d_read | d_write) & ~d_ready;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port backing memory between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the MIPS32 pipeline.
- Data accesses come from lw/sw, driven by the control unit's MemRead/MemWrite.
- The block arbitrates between the two requesters, sequences each access through a request/acknowledge handshake, and returns read data with a one-cycle ready pulse.
- It also produces stall signals for the pipeline and enforces a fetch anti-starvation limit and an access timeout.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before fetch is forced
- TIMEOUT, 64, cycles in BUSY without mem_ack before the access is aborted

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, held until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle fetch completion pulse
- d_read  in  1  data read request (lw), held until d_ready
- d_write  in  1  data write request (sw), held until d_ready
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_rdata  out  DATA_W  load data, registered
- d_ready  out  1  one-cycle data completion pulse
- err  out  1  one-cycle pulse, coincident with ready, on timeout abort
- stall_if  out  1  if_req & ~if_ready (combinational)
- stall_mem  out  1  (d_read|d_write) & ~d_ready (combinational)
- mem_req  out  1  memory request, registered
- mem_we  out  1  memory write enable, registered
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data, valid when mem_ack=1
- mem_ack  in  1  single-cycle acknowledge from memory

Behaviour:
- Reset: state IDLE. All registered outputs are 0: mem_req, mem_we, mem_addr, mem_wdata, if_rdata, d_rdata, if_ready, d_ready, err. Streak and timeout counters are 0.
- Reset asserted mid-access: mem_req drops at that edge and no ready pulse is issued. A late mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, BUSY, DONE.
- Owner register records which requester (I or D) holds the current access.

IDLE (arbitration, evaluated only in this state):
- Data pending = d_read|d_write.
- Both pending and streak < MAX_D_STREAK: grant D and increment streak.
- Both pending and streak == MAX_D_STREAK: grant I and clear streak.
- Only D pending: grant D. Streak is cleared, since no fetch is waiting.
- Only I pending: grant I and clear streak.
- On grant, at the next edge:
  - Latch mem_addr, mem_wdata and mem_we.
  - mem_we = d_write for a D grant, 0 for an I grant.
  - Set mem_req=1 and go to BUSY.
- d_read and d_write both high: treated as a write.

BUSY:
- mem_req and the latched fields are held stable.
- Timeout counter increments each cycle.
- mem_ack=1: at that edge, mem_rdata is captured into the owner's rdata register (captured for writes too). The owner's ready=1, mem_req=0, and the state goes to DONE.
- Counter reaches TIMEOUT-1 without ack: at that edge, the owner's rdata=0, ready=1, err=1, mem_req=0, and the state goes to DONE.

DONE:
- Ready (and err, if set) is high for exactly this cycle, then clears.
- No arbitration in DONE. The requester advances on this edge and may present a new request seen in the following IDLE.
- Next state is IDLE.

Timing and invariants:
- Minimum latency: request seen in IDLE cycle t, mem_req high from t+1. If ack arrives at t+1, ready is high in t+2. Sustained throughput is one access per 3 cycles.
- Requests dropped by a requester while not owner are simply not granted. Inputs of the current owner are not sampled after the grant.
- Only the owner's ready/rdata ever changes. The other requester's rdata holds its last value.

Test Plan:
- Single fetch: if_req=1, if_addr=0x0000_0040, mem_ack one cycle after mem_req with mem_rdata=0x8C08_0004 -> mem_req high 1 cycle with mem_we=0 and mem_addr=0x40; next cycle if_ready=1, if_rdata=0x8C08_0004; stall_if low only in that cycle.
- Store: d_write=1, d_addr=0x100, d_wdata=0xDEAD_BEEF -> mem_we=1, mem_addr=0x100, mem_wdata=0xDEAD_BEEF; d_ready pulses once after ack; if_ready stays 0.
- Contention with starvation limit: if_req and d_read both held continuously, with immediate acks -> grants D,D,D,D,I,D,D,D,D,I (MAX_D_STREAK=4), each grant separated by DONE/IDLE.
- Timeout: d_read=1, mem_ack never asserted -> after 64 BUSY cycles, d_ready=1, err=1, d_rdata=0; FSM returns to IDLE; a subsequent fetch completes normally.
- Reset mid-access: reset asserted in the second BUSY cycle of a fetch -> mem_req=0 and all outputs 0 next cycle; no if_ready pulse; an ack in the cycle after reset is ignored.
- Read+write conflict and back-to-back: d_read=d_write=1 -> mem_we=1. Requester re-asserts in the cycle after DONE -> new mem_req exactly 2 cycles after the previous ready.
